operand_fetch: RTL
==================

# operand_fetch

Register-read stage of the MIPS pipeline, sitting between decode and execute and acting as the reader of the register file. It drives the register file's read addresses, captures both operands into an output pipeline register, and tracks in-flight writes in a 32-entry scoreboard so no instruction leaves with a stale operand. It also observes the write-back port, so read-after-write hazards are resolved by stalling or by same-cycle bypass.

## Interface
- `NREGS`, 32: architectural register count; register 0 is hard-wired zero.
- `DW`, 32: data width.
- `Clk`  in  1  rising-edge clock shared with `Register_File`.
- `Rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  stage accepts it this cycle.
- `in_rs`, `in_rt`, `in_rd`  in  5 each  source and destination register numbers.
- `in_rd_wen`  in  1  instruction will write `in_rd`.
- `in_instr`  in  DW  instruction word, passed through unchanged.
- `Ard1`, `Ard2`  out  5  register-file read addresses; combinationally equal to `in_rs` and `in_rt`.
- `Dout1`, `Dout2`  in  DW  register-file read data. Reads are combinational.
- `wb_en`, `wb_addr`, `wb_data`  in  1/5/DW  write-back port. These are the same signals that drive `WrEn`, `Awr` and `Din`.
- `out_valid`  out  1  operand bundle valid.
- `out_ready`  in  1  execute accepts the bundle.
- `out_a`, `out_b`  out  DW  operand values for rs and rt.
- `out_rd`, `out_rd_wen`, `out_instr`  out  5/1/DW  registered pass-through of the accepted instruction's fields.
- `busy_cnt`  out  6  number of set scoreboard bits.

## Operation
- **Scoreboard:** `busy[31:0]`. Bit 0 is always 0.
  - Accepting an instruction with `in_rd_wen=1` and `in_rd!=0` sets `busy[in_rd]`.
  - `wb_en=1` clears `busy[wb_addr]`.
  - If both events hit the same index in the same cycle, the set wins, because it belongs to a newer pending write.
- **Hazard:** a source register is hazardous when `busy[src]=1`, unless the bypass applies (see Configuration).
- **Output buffer FSM:** two states, EMPTY (`out_valid=0`) and FULL (`out_valid=1`).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on `out_ready` with no accept.
  - FULL→FULL on `out_ready` together with an accept (back-to-back flow).
  - FULL holds all output registers stable while `out_ready=0`.
- **Accept rule:** accept happens when `in_valid && in_ready`, where `in_ready = !hazard_rs && !hazard_rt && (!out_valid || out_ready)`. `in_ready` must not depend on `in_valid`.
- **Operand select:**
  - Source index 0 yields 0.
  - A bypass hit yields `wb_data`.
  - Otherwise the operand is `Dout1` or `Dout2`.
- **`busy_cnt`:** registered; increments on a set, decrements on a clear, and is unchanged when both occur in one cycle. It saturates at 31 and never underflows.
- **Spurious write-back:** a write-back to a non-busy register, or to register 0, is legal and has no scoreboard effect.

## Timing
- **Reset values:** `busy=0`, `busy_cnt=0`, `out_valid=0`, `out_a=out_b=0`, `out_rd=0`, `out_rd_wen=0`, `out_instr=0`. `in_ready=1` during the cycle after reset.
- **Latency:** 1 cycle from accept to `out_valid`. Throughput is 1 per cycle when there are no hazards and `out_ready=1`.
- **Stall:** on a hazard, the stage holds the instruction at its input with `in_ready=0`.
  - With bypass: the instruction is accepted in the write-back cycle.
  - Without bypass: the instruction is accepted the cycle after the write-back, when the register file holds the new value.
- **Scoreboard update:** changes at the rising edge, so a dependent instruction issued directly behind its producer sees `busy` set and stalls.
- **Reset mid-operation:**
  - Asserting `Rst` drops the buffered bundle and clears the whole scoreboard at the next edge.
  - Write-backs arriving during that edge are ignored.

## Configuration
- **`OPFETCH_WB_BYPASS_EN` defined:**
  - A hazard on `src` is waived when `wb_en && wb_addr==src && src!=0`.
  - In that case the operand is taken from `wb_data`.
- **Not defined:**
  - No bypass logic is compiled in.
  - `busy[src]` alone stalls the instruction.
  - Operands always come from `Dout1` or `Dout2`, which costs one extra stall cycle per write-back dependency.

## Structure
- **Shared package `mips_pkg`:** holds `NREGS`, `DW`, the `regaddr_t` (5-bit) and `word_t` typedefs, and the `REG_ZERO` constant.
- **Sub-module `reg_scoreboard`:** the busy vector, its set/clear priority, `busy_cnt`, and the two hazard lookups. The top level holds the handshake, operand mux and output register.

## Test plan
- **Basic flow:** regfile r1=1, r2=2, no busy bits; issue rs=1, rt=2, rd=3 with wen=1 → next cycle `out_valid=1`, `out_a=1`, `out_b=2`, `out_rd=3`; `busy[3]=1` and `busy_cnt=1`.
- **Stall then release:** issue rd=3, then immediately rs=3, stall the second instruction for two cycles, then write back r3=0x0000_0003.
  - With the bypass: the second instruction is accepted in the write-back cycle with `out_a=3`.
  - Without the bypass: it is accepted one cycle later with `out_a=3`.
- **Back-pressure:** hold `out_ready=0` for 3 cycles with `out_valid=1` → outputs stable and `in_ready=0`. Raising `out_ready` with a new `in_valid` → back-to-back transfer with no bubble.
- **Register zero:** issue rs=0, rt=0, rd=0 with wen=1, `Dout1`=0xFFFF_FFFF → `out_a=out_b=0`, `busy_cnt` stays 0.
- **Same-cycle priority:** while r31 is busy, write back r31 (value 0xFFFF_FFFF) in the same cycle as accepting a new instruction with rd=31 → `busy[31]` remains 1 and `busy_cnt` is unchanged.
- **Reset mid-operation:** `Rst=1` for 1 cycle with `out_valid=1` and `busy_cnt=4` → next cycle `out_valid=0`, `busy_cnt=0`, `in_ready=1`.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, register-address/word types and buffer state encoding
package mips_pkg;
    localparam int NREGS = 32;
    localparam int DW = 32;
    typedef logic [4:0] regaddr_t;
    typedef logic [DW-1:0] word_t;
    localparam regaddr_t REG_ZERO = 5'd0;
    typedef enum logic {EMPTY, FULL} buf_state_t;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: in-flight write tracking, set-over-clear priority, busy count and hazard lookups
module reg_scoreboard
    import mips_pkg::*;
#(
    parameter int NREGS = mips_pkg::NREGS
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       set_en,
    input  logic [4:0] set_addr,
    input  logic       clr_en,
    input  logic [4:0] clr_addr,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       byp_rs,
    input  logic       byp_rt,
    output logic       hazard_rs,
    output logic       hazard_rt,
    output logic [5:0] busy_cnt
);
    logic [NREGS-1:0] busy, busy_next;
    logic [5:0] cnt_next;

    // Clear first, then set, so a newer pending write on the same index survives; count follows the vector
    always_comb begin
        busy_next = busy;
        if (clr_en) busy_next[clr_addr] = 1'b0;
        if (set_en && set_addr != REG_ZERO) busy_next[set_addr] = 1'b1;
        busy_next[0] = 1'b0;
        cnt_next = '0;
        for (int i = 1; i < NREGS; i++) cnt_next = cnt_next + 6'(busy_next[i]);
    end

    // Scoreboard state; reset drops every pending write, including one arriving this edge
    always_ff @(posedge Clk) begin
        if (Rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

    assign hazard_rs = busy[rs] && !byp_rs;
    assign hazard_rt = busy[rt] && !byp_rt;
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage with scoreboard stalls; OPFETCH_WB_BYPASS_EN enables write-back bypass
module operand_fetch
    import mips_pkg::*;
#(
    parameter int NREGS = mips_pkg::NREGS,
    parameter int DW    = mips_pkg::DW
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic          in_rd_wen,
    input  logic [DW-1:0] in_instr,
    output logic [4:0]    Ard1,
    output logic [4:0]    Ard2,
    input  logic [DW-1:0] Dout1,
    input  logic [DW-1:0] Dout2,
    input  logic          wb_en,
    input  logic [4:0]    wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic [4:0]    out_rd,
    output logic          out_rd_wen,
    output logic [DW-1:0] out_instr,
    output logic [5:0]    busy_cnt
);
    buf_state_t state, state_next;
    logic hazard_rs, hazard_rt, byp_rs, byp_rt, accept;
    logic [DW-1:0] opa, opb;

    assign Ard1 = in_rs;
    assign Ard2 = in_rt;

`ifdef OPFETCH_WB_BYPASS_EN
    assign byp_rs = wb_en && wb_addr == in_rs && in_rs != REG_ZERO;
    assign byp_rt = wb_en && wb_addr == in_rt && in_rt != REG_ZERO;
    assign opa = in_rs == REG_ZERO ? '0 : byp_rs ? wb_data : Dout1;
    assign opb = in_rt == REG_ZERO ? '0 : byp_rt ? wb_data : Dout2;
`else
    assign byp_rs = 1'b0;
    assign byp_rt = 1'b0;
    assign opa = in_rs == REG_ZERO ? '0 : Dout1;
    assign opb = in_rt == REG_ZERO ? '0 : Dout2;
`endif

    assign in_ready = !hazard_rs && !hazard_rt && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    reg_scoreboard #(.NREGS(NREGS)) u_sb (
        .Clk      (Clk),
        .Rst      (Rst),
        .set_en   (accept && in_rd_wen),
        .set_addr (in_rd),
        .clr_en   (wb_en),
        .clr_addr (wb_addr),
        .rs       (in_rs),
        .rt       (in_rt),
        .byp_rs   (byp_rs),
        .byp_rt   (byp_rt),
        .hazard_rs(hazard_rs),
        .hazard_rt(hazard_rt),
        .busy_cnt (busy_cnt)
    );

    // Output buffer state register
    always_ff @(posedge Clk) begin
        if (Rst) state <= EMPTY;
        else state <= state_next;
    end

    // Fill on accept, drain when execute takes the bundle without a replacement
    always_comb begin
        state_next = accept ? FULL : out_ready ? EMPTY : state;
    end

    // Bundle valid whenever the buffer is full
    always_comb begin
        out_valid = state == FULL;
    end

    // Operand bundle loads only on accept, so it holds stable under back-pressure
    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_a      <= '0;
            out_b      <= '0;
            out_rd     <= '0;
            out_rd_wen <= 1'b0;
            out_instr  <= '0;
        end else if (accept) begin
            out_a      <= opa;
            out_b      <= opb;
            out_rd     <= in_rd;
            out_rd_wen <= in_rd_wen;
            out_instr  <= in_instr;
        end
    end
endmodule
